regfile_scoreboard: RTL and testbench



---
 rtl/rv_pkg.sv | 15 +
 rtl/regfile_busy_tracker.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 70 +++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file types and defaults for the integer datapath.
package rv_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF = aw_of(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   regaddr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;
endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: issue sets, writeback clears, set wins on a tie.
module regfile_busy_tracker
  import rv_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = aw_of(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_vld,
  input  logic [AW-1:0]    i_set_reg,
  input  logic             i_clr_vld,
  input  logic [AW-1:0]    i_clr_reg,
  output logic [NREGS-1:0] o_busy,
  output logic [AW:0]      o_count
);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_count;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_count_nxt;

  // Clear is applied first so a same-register issue re-marks it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_vld && i_clr_reg != AW'(ZERO_REG))
      w_busy_nxt[i_clr_reg] = 1'b0;
    if (i_set_vld && i_set_reg != AW'(ZERO_REG))
      w_busy_nxt[i_set_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      w_count_nxt = w_count_nxt + (AW+1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: NREAD combinational reads, one write, optional bypass,
// and a busy scoreboard for RAW hazard detection at decode.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int AW     = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   readAddr,
  output logic [NREAD*XLEN-1:0] readData,
  output logic [NREAD-1:0]      readBusy,
  input  logic                  regWrite,
  input  logic [AW-1:0]         writeReg,
  input  logic [XLEN-1:0]       writeData,
  input  logic                  issueValid,
  input  logic [AW-1:0]         issueReg,
  output logic [NREGS-1:0]      busyVec,
  output logic [AW:0]           pendingCount
);

  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $fatal(1, "regfile_scoreboard: NREGS must be a power of 2 and >= 2");
  end
  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $fatal(1, "regfile_scoreboard: NREAD must be in 1..4");
  end

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wr_en;

  assign w_wr_en = regWrite && (writeReg != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[writeReg] <= writeData;
    end
  end

  regfile_busy_tracker #(.NREGS(NREGS), .AW(AW)) u_busy (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_vld (issueValid),
    .i_set_reg (issueReg),
    .i_clr_vld (regWrite),
    .i_clr_reg (writeReg),
    .o_busy    (busyVec),
    .o_count   (pendingCount)
  );

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;

    assign w_addr = readAddr[p*AW +: AW];
    // A bypassed read already carries the result, so the hazard is resolved.
    assign w_hit  = (BYPASS != 0) && w_wr_en && (writeReg == w_addr);

    assign readData[p*XLEN +: XLEN] = (w_addr == AW'(ZERO_REG)) ? '0 :
                                      w_hit ? writeData : r_mem[w_addr];
    assign readBusy[p] = busyVec[w_addr] & ~w_hit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: bypass and non-bypass instances on shared stimulus, checked each cycle
// against an array-based model plus hand-computed expectations.
module tb_regfile_scoreboard;
  localparam int XL = 64;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int A  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*A-1:0] readAddr;
  logic            regWrite;
  logic [A-1:0]    writeReg;
  logic [XL-1:0]   writeData;
  logic            issueValid;
  logic [A-1:0]    issueReg;

  logic [NP*XL-1:0] rd1, rd0;
  logic [NP-1:0]    rb1, rb0;
  logic [NR-1:0]    bv1, bv0;
  logic [A:0]       pc1, pc0;

  int n_cmp = 0;
  int n_bad = 0;

  bit [XL-1:0] mem   [NR];
  bit          mbusy [NR];

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XL), .NREGS(NR), .NREAD(NP), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .readAddr(readAddr), .readData(rd1), .readBusy(rb1),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .issueValid(issueValid), .issueReg(issueReg), .busyVec(bv1), .pendingCount(pc1));

  regfile_scoreboard #(.XLEN(XL), .NREGS(NR), .NREAD(NP), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .readAddr(readAddr), .readData(rd0), .readBusy(rb0),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .issueValid(issueValid), .issueReg(issueReg), .busyVec(bv0), .pendingCount(pc0));

  // Architectural model: clear on writeback, then set on issue (newer producer wins).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin mem[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      if (regWrite && writeReg != 0) begin
        mem[writeReg]   = writeData;
        mbusy[writeReg] = 1'b0;
      end
      if (issueValid && issueReg != 0) mbusy[issueReg] = 1'b1;
    end
  end

  function automatic logic [XL-1:0] exp_rd(input bit byp, input logic [A-1:0] a);
    if (a == 0) return '0;
    if (byp && regWrite && writeReg == a) return writeData;
    return mem[a];
  endfunction

  function automatic logic exp_rb(input bit byp, input logic [A-1:0] a);
    if (a == 0) return 1'b0;
    if (byp && regWrite && writeReg == a) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic [NR-1:0] exp_bv();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int exp_pc();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      chk("rd_byp",   rd1[p*XL +: XL], exp_rd(1'b1, readAddr[p*A +: A]));
      chk("rd_nob",   rd0[p*XL +: XL], exp_rd(1'b0, readAddr[p*A +: A]));
      chk("busy_byp", XL'(rb1[p]),     XL'(exp_rb(1'b1, readAddr[p*A +: A])));
      chk("busy_nob", XL'(rb0[p]),     XL'(exp_rb(1'b0, readAddr[p*A +: A])));
    end
    chk("busyvec_byp", XL'(bv1), XL'(exp_bv()));
    chk("busyvec_nob", XL'(bv0), XL'(exp_bv()));
    chk("pcount_byp",  XL'(pc1), XL'(exp_pc()));
    chk("pcount_nob",  XL'(pc0), XL'(exp_pc()));
  end

  // One cycle: apply inputs just after the edge, return just after the negedge.
  task automatic step(input logic [A-1:0] a0, input logic [A-1:0] a1,
                      input logic we, input logic [A-1:0] wr, input logic [XL-1:0] wd,
                      input logic iv, input logic [A-1:0] ir);
    @(posedge clk); #1;
    readAddr = {a1, a0}; regWrite = we; writeReg = wr; writeData = wd;
    issueValid = iv; issueReg = ir;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [A-1:0] a0, input logic [A-1:0] a1);
    step(a0, a1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0; readAddr = '0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    issueValid = 1'b0; issueReg = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset state on every address
    for (int a = 0; a < NR; a++) begin
      idle(A'(a), A'(a));
      chk("rst_rd", rd1[XL-1:0], '0);
    end
    chk("rst_bv", XL'(bv1), '0);
    chk("rst_pc", XL'(pc1), '0);

    // Write x5, then x0
    step(0, 0, 1'b1, 5, 64'hDEADBEEF_CAFEF00D, 1'b0, 0);
    idle(5, 5);
    chk("x5_p0", rd1[XL-1:0],  64'hDEADBEEF_CAFEF00D);
    chk("x5_p1", rd1[2*XL-1:XL], 64'hDEADBEEF_CAFEF00D);
    chk("x5_nob", rd0[XL-1:0], 64'hDEADBEEF_CAFEF00D);
    step(0, 0, 1'b1, 0, 64'h1234, 1'b0, 0);
    chk("x0_wr_cycle", rd1[XL-1:0], '0);
    idle(0, 0);
    chk("x0_after", rd1[XL-1:0], '0);

    // Issue+write x7 together (stays busy), then bypass a write to x7
    step(0, 0, 1'b1, 7, 64'h11, 1'b1, 7);
    step(7, 0, 1'b1, 7, 64'hA5, 1'b0, 0);
    chk("byp_data",  rd1[XL-1:0], 64'hA5);
    chk("byp_busy",  XL'(rb1[0]), 64'h0);
    chk("nob_data",  rd0[XL-1:0], 64'h11);
    chk("nob_busy",  XL'(rb0[0]), 64'h1);

    // Issue x3, then retire it
    step(0, 0, 1'b0, 0, 0, 1'b1, 3);
    idle(3, 0);
    chk("x3_bv",   XL'(bv1[3]), 64'h1);
    chk("x3_rb",   XL'(rb1[0]), 64'h1);
    chk("x3_pc1",  XL'(pc1),    64'd1);
    step(0, 0, 1'b1, 3, 64'h33, 1'b0, 0);
    idle(3, 0);
    chk("x3_clr",  XL'(bv1[3]), 64'h0);
    chk("x3_pc0",  XL'(pc1),    64'd0);

    // Set and clear on the same, then different registers
    step(0, 0, 1'b1, 9, 64'h99, 1'b1, 9);
    idle(9, 0);
    chk("x9_bv",   XL'(bv1[9]), 64'h1);
    chk("x9_data", rd0[XL-1:0], 64'h99);
    step(0, 0, 1'b1, 9, 64'h9A, 1'b1, 4);
    idle(9, 4);
    chk("x4_bv",   XL'(bv1[4]), 64'h1);
    chk("x9_clr",  XL'(bv1[9]), 64'h0);
    chk("x9_data2", rd0[XL-1:0], 64'h9A);
    chk("pc_x4",   XL'(pc1),    64'd1);

    // Busy x1..x10, then reset mid-cycle
    step(0, 0, 1'b1, 1, 64'h1111, 1'b0, 0);
    for (int r = 1; r <= 10; r++) step(0, 0, 1'b0, 0, 0, 1'b1, A'(r));
    idle(1, 0);
    chk("pc10",    XL'(pc1),    64'd10);
    chk("bv10",    XL'(bv1),    64'h7FE);
    chk("x1_pre",  rd1[XL-1:0], 64'h1111);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bv_mid", XL'(bv1), '0);
    chk("rst_pc_mid", XL'(pc1), '0);
    chk("rst_x1_mid", rd1[XL-1:0], '0);
    chk("rst_x1_nob", rd0[XL-1:0], '0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 60; i++)
      step(A'(i), A'(i * 7), (i % 3) != 0, A'(i * 5), {32'(i), ~32'(i)}, (i % 2) == 0, A'(i * 3 + 1));
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
